song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Built-in song player feeding the Controler stage: given the song select (songs, 0 = none),
//  steps through a per-song note ROM and emits note codes on oSong_Data (-> iSong_Data).
//  Each note is held for its duration in tempo ticks, followed by a short silent gap.
//  Sits between Controler's songs output and its iSong_Data input; output feeds BuzzerDecoder via Controler.
// PARAMETERS
//  TICK_DIV    12_500_000  clock cycles per tempo tick (1/8 s @100 MHz); >=1
//  GAP_CYCLES  1_250_000   silent cycles (code 99) inserted after every note; 0 = no gap
//  MAX_NOTES   64          ROM depth per song; index width = clog2(MAX_NOTES)
//  LOOP        1           1 = restart song at end, 0 = stop in DONE
// PORTS
//  iClk           in   1  system clock
//  iReset         in   1  asynchronous reset, active high
//  iSongs         in   5  signed song select; 1 = song A, 2 = song B, any other value = none
//  oSong_Data     out  8  note code to Controler; 99 = rest/silence, 0 = idle
//  oNoteStrobe    out  1  one-cycle pulse on the first cycle a new note code is presented
//  oSongDone      out  1  one-cycle pulse when the end-of-song entry is reached
//  oNoteIndex     out  6  current ROM index (width = clog2(MAX_NOTES))
// BEHAVIOUR
//  Reset (async, iReset=1): state IDLE, oSong_Data=0, oNoteStrobe=0, oSongDone=0, oNoteIndex=0,
//   all counters 0. Release is synchronous to iClk.
//  ROM: per song, MAX_NOTES entries of {code[7:0], dur[3:0]}; code 0 = end-of-song marker.
//   dur = tempo ticks; dur 0 is treated as 1. Song A entry0 = {11,2}, entry1 = {12,1}, entry2 = {0,x}.
//   Song B entry0 = {21,4}, entry1 = {0,x}. Remaining table contents live in the ROM case list.
//  Registered select sel_q = iSongs if iSongs in {1,2}, else 0 (negative values -> 0).
//  States: IDLE, LOAD, PLAY, GAP, DONE.
//   IDLE : oSong_Data=0. sel_q!=0 -> LOAD with index=0.
//   LOAD : one cycle; reads ROM[sel_q][index] into registers. code==0 or index==MAX_NOTES -> end handling;
//          else -> PLAY.
//   PLAY : oSong_Data=code; oNoteStrobe=1 on first PLAY cycle only; lasts dur*TICK_DIV cycles exactly.
//          Then -> GAP (or LOAD with index+1 if GAP_CYCLES==0).
//   GAP  : oSong_Data=99 for GAP_CYCLES cycles; then index+1 -> LOAD.
//   End handling: oSongDone=1 for one cycle; LOOP=1 -> index=0, LOAD; LOOP=0 -> DONE.
//   DONE : oSong_Data=99, holds until sel_q changes.
//  Latency: iSongs sampled at edge k -> sel_q valid k; LOAD at k+1; first note on oSong_Data and
//   oNoteStrobe at edge k+2.
//  Song change mid-play (sel_q differs from previous sel_q, both nonzero): abort current note,
//   counters cleared, index=0, -> LOAD next cycle; no oSongDone pulse.
//  sel_q -> 0 from any state: -> IDLE next edge, oSong_Data=0 same edge; index cleared.
//  Tick counter wraps at TICK_DIV-1 and is cleared on every LOAD; duration counter never underflows.
//  Index never exceeds MAX_NOTES-1 on oNoteIndex; a full ROM without a 0 marker ends like code 0.
//  All outputs registered; no combinational path from iSongs to any output.
// TESTING  (TICK_DIV=4, GAP_CYCLES=2, LOOP=1 unless stated)
//  1 Reset: hold iReset=1, drive iSongs=1 -> outputs 0, state IDLE; release -> first note 2 cycles later.
//  2 Song A: iSongs=1 at edge 0 -> oSong_Data=11 edges 2..9 (8 cyc) with strobe at 2, 99 for 2 cyc,
//    LOAD, 12 for 4 cyc, 99 for 2 cyc, LOAD, oSongDone pulse, index 0, 11 again with strobe.
//  3 LOOP=0, song B: 21 for 16 cycles, 99 x2, oSongDone once, then oSong_Data=99 held 50+ cycles.
//  4 Switch mid-note: song A playing code 11, set iSongs=2 -> 1 cycle LOAD, then 21 with strobe,
//    oNoteIndex=0, no oSongDone.
//  5 Stop: iSongs 1->0 during GAP -> oSong_Data=0 next edge, IDLE; iSongs=-3 or 5 -> stays IDLE.
//  6 Async reset mid-PLAY (between clock edges) -> all outputs 0 immediately, no clock needed.

Source files
------------

// File: rtl/song_sequencer.sv
// Built-in song player: walks a per-song note ROM and presents note codes to the
// Controler stage, holding each note for its tempo duration followed by a silent gap.
module song_sequencer #(
    parameter int TICK_DIV   = 12_500_000,
    parameter int GAP_CYCLES = 1_250_000,
    parameter int MAX_NOTES  = 64,
    parameter int LOOP       = 1
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic signed [4:0]            iSongs,
    output logic [7:0]                   oSong_Data,
    output logic                         oNoteStrobe,
    output logic                         oSongDone,
    output logic [$clog2(MAX_NOTES)-1:0] oNoteIndex
);
    localparam int IDX_W = $clog2(MAX_NOTES);
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(MAX_NOTES - 1);
    localparam logic [7:0]       REST      = 8'd99;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} stateT;

    stateT            stateReg, stateNext;
    logic [1:0]       selQ, selPrev, selIn;
    logic [TW-1:0]    tickReg, tickNext;
    logic [3:0]       durReg, durNext;
    logic [GW-1:0]    gapReg, gapNext;
    logic             atEndReg, atEndNext;
    logic [IDX_W-1:0] indexNext;
    logic [7:0]       dataNext;
    logic             strobeNext, doneNext;
    logic [11:0]      romWord;
    logic             songChange, atLast;

    // Note table: {code, duration in ticks}; code 0 marks the end of a song.
    function automatic logic [11:0] romRead(input logic [1:0] sel, input logic [IDX_W-1:0] idx);
        logic [11:0] w;
        w = 12'h000;
        case (sel)
            2'd1: begin
                case (idx)
                    IDX_W'(0): w = {8'd11, 4'd2};
                    IDX_W'(1): w = {8'd12, 4'd1};
                    default:   w = 12'h000;
                endcase
            end
            2'd2: begin
                case (idx)
                    IDX_W'(0): w = {8'd21, 4'd4};
                    default:   w = 12'h000;
                endcase
            end
            default: w = 12'h000;
        endcase
        return w;
    endfunction

    always_comb begin
        selIn = 2'd0;
        if (iSongs == 5'sd1)
            selIn = 2'd1;
        else if (iSongs == 5'sd2)
            selIn = 2'd2;
    end

    assign romWord    = romRead(selQ, oNoteIndex);
    assign songChange = (selQ != selPrev) && (selQ != 2'd0) && (selPrev != 2'd0);
    assign atLast     = (oNoteIndex == MAX_IDX);

    always_comb begin
        stateNext  = stateReg;
        dataNext   = oSong_Data;
        strobeNext = 1'b0;
        doneNext   = 1'b0;
        indexNext  = oNoteIndex;
        atEndNext  = atEndReg;
        tickNext   = tickReg;
        durNext    = durReg;
        gapNext    = gapReg;

        if (selQ == 2'd0) begin
            stateNext = IDLE;
            dataNext  = 8'd0;
            indexNext = '0;
            atEndNext = 1'b0;
            tickNext  = '0;
            durNext   = '0;
            gapNext   = '0;
        end else if (songChange) begin
            // Abort whatever is playing and restart the new song from its first entry.
            stateNext = LOAD;
            indexNext = '0;
            atEndNext = 1'b0;
            tickNext  = '0;
            durNext   = '0;
            gapNext   = '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    stateNext = LOAD;
                    indexNext = '0;
                    atEndNext = 1'b0;
                end
                LOAD: begin
                    tickNext = '0;
                    gapNext  = '0;
                    if (atEndReg || romWord[11:4] == 8'd0) begin
                        doneNext = 1'b1;
                        if (LOOP != 0) begin
                            stateNext = LOAD;
                            indexNext = '0;
                            atEndNext = 1'b0;
                        end else begin
                            stateNext = DONE;
                            dataNext  = REST;
                        end
                    end else begin
                        stateNext  = PLAY;
                        dataNext   = romWord[11:4];
                        strobeNext = 1'b1;
                        durNext    = (romWord[3:0] == 4'd0) ? 4'd1 : romWord[3:0];
                    end
                end
                PLAY: begin
                    if (tickReg == TICK_LAST) begin
                        tickNext = '0;
                        if (durReg <= 4'd1) begin
                            if (GAP_CYCLES == 0) begin
                                stateNext = LOAD;
                                if (atLast) atEndNext = 1'b1;
                                else        indexNext = oNoteIndex + IDX_W'(1);
                            end else begin
                                stateNext = GAP;
                                dataNext  = REST;
                                gapNext   = '0;
                            end
                        end else begin
                            durNext = durReg - 4'd1;
                        end
                    end else begin
                        tickNext = tickReg + TW'(1);
                    end
                end
                GAP: begin
                    if (gapReg == GAP_LAST) begin
                        stateNext = LOAD;
                        gapNext   = '0;
                        if (atLast) atEndNext = 1'b1;
                        else        indexNext = oNoteIndex + IDX_W'(1);
                    end else begin
                        gapNext = gapReg + GW'(1);
                    end
                end
                DONE: begin
                    dataNext = REST;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            stateReg    <= IDLE;
            selQ        <= 2'd0;
            selPrev     <= 2'd0;
            tickReg     <= '0;
            durReg      <= '0;
            gapReg      <= '0;
            atEndReg    <= 1'b0;
            oSong_Data  <= 8'd0;
            oNoteStrobe <= 1'b0;
            oSongDone   <= 1'b0;
            oNoteIndex  <= '0;
        end else begin
            stateReg    <= stateNext;
            selQ        <= selIn;
            selPrev     <= selQ;
            tickReg     <= tickNext;
            durReg      <= durNext;
            gapReg      <= gapNext;
            atEndReg    <= atEndNext;
            oSong_Data  <= dataNext;
            oNoteStrobe <= strobeNext;
            oSongDone   <= doneNext;
            oNoteIndex  <= indexNext;
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: per-cycle expected output stream for a looping
// instance (song A/B, switch, stop) and a non-looping instance, plus reset corner cases.
module tb_song_sequencer;
    logic              iClk = 1'b0;
    logic              iReset;
    logic signed [4:0] songsA, songsB;
    logic [7:0]        dataA, dataB;
    logic              strobeA, strobeB, doneA, doneB;
    logic [5:0]        idxA, idxB;

    int nVec = 0;
    int nErr = 0;

    always #5 iClk = ~iClk;

    song_sequencer #(.TICK_DIV(4), .GAP_CYCLES(2), .MAX_NOTES(64), .LOOP(1)) dutA (
        .iClk(iClk), .iReset(iReset), .iSongs(songsA), .oSong_Data(dataA),
        .oNoteStrobe(strobeA), .oSongDone(doneA), .oNoteIndex(idxA)
    );

    song_sequencer #(.TICK_DIV(4), .GAP_CYCLES(2), .MAX_NOTES(64), .LOOP(0)) dutB (
        .iClk(iClk), .iReset(iReset), .iSongs(songsB), .oSong_Data(dataB),
        .oNoteStrobe(strobeB), .oSongDone(doneB), .oNoteIndex(idxB)
    );

    typedef struct {
        int                dut;
        logic signed [4:0] songs;
        logic [7:0]        data;
        logic              strobe;
        logic              done;
        logic [5:0]        idx;
        logic              chkIdx;
        string             tag;
    } vecT;

    vecT vecs[$];
    vecT expQ[$];

    // Appends n cycles of identical expectations; the strobe is expected only on the first.
    task automatic addVec(input int dut, input int songs, input int data, input bit strobe,
                          input bit done, input int idx, input bit chkIdx, input int n,
                          input string tag);
        vecT v;
        for (int k = 0; k < n; k++) begin
            v.dut    = dut;
            v.songs  = 5'(songs);
            v.data   = 8'(data);
            v.strobe = (k == 0) ? strobe : 1'b0;
            v.done   = done;
            v.idx    = 6'(idx);
            v.chkIdx = chkIdx;
            v.tag    = tag;
            vecs.push_back(v);
        end
    endtask

    task automatic checkVec(input vecT e, input int n);
        logic [7:0] d;
        logic       s, dn;
        logic [5:0] ix;
        bit         bad;
        if (e.dut == 0) begin
            d = dataA; s = strobeA; dn = doneA; ix = idxA;
        end else begin
            d = dataB; s = strobeB; dn = doneB; ix = idxB;
        end
        bad = (d != e.data) || (s != e.strobe) || (dn != e.done) || (e.chkIdx && (ix != e.idx));
        nVec++;
        if (bad) begin
            nErr++;
            $display("FAIL %s #%0d: got data=%0d strobe=%0b done=%0b idx=%0d, want data=%0d strobe=%0b done=%0b idx=%0d",
                     e.tag, n, d, s, dn, ix, e.data, e.strobe, e.done, e.idx);
        end else begin
            $display("ok   %s #%0d: data=%0d strobe=%0b done=%0b idx=%0d", e.tag, n, d, s, dn, ix);
        end
    endtask

    task automatic checkIdle(input string tag, input logic [7:0] d, input logic s,
                             input logic dn, input logic [5:0] ix);
        nVec++;
        if (d != 8'd0 || s != 1'b0 || dn != 1'b0 || ix != 6'd0) begin
            nErr++;
            $display("FAIL %s: got data=%0d strobe=%0b done=%0b idx=%0d, want all 0", tag, d, s, dn, ix);
        end else begin
            $display("ok   %s: outputs 0", tag);
        end
    endtask

    initial begin
        vecT v, e;
        bit  found;

        // Song A from reset release, looping instance
        addVec(0, 1,  0, 0, 0, 0, 1, 2,  "A_start");
        addVec(0, 1, 11, 1, 0, 0, 1, 8,  "A_note0");
        addVec(0, 1, 99, 0, 0, 0, 1, 2,  "A_gap0");
        addVec(0, 1, 99, 0, 0, 1, 1, 1,  "A_load1");
        addVec(0, 1, 12, 1, 0, 1, 1, 4,  "A_note1");
        addVec(0, 1, 99, 0, 0, 1, 1, 2,  "A_gap1");
        addVec(0, 1, 99, 0, 0, 2, 1, 1,  "A_load2");
        addVec(0, 1, 99, 0, 1, 0, 1, 1,  "A_done");
        addVec(0, 1, 11, 1, 0, 0, 1, 2,  "A_loop");
        // Switch to song B in the middle of note 11
        addVec(0, 2, 11, 0, 0, 0, 1, 2,  "sw_abort");
        addVec(0, 2, 21, 1, 0, 0, 1, 16, "B_note0");
        addVec(0, 2, 99, 0, 0, 0, 1, 2,  "B_gap");
        addVec(0, 2, 99, 0, 0, 1, 1, 1,  "B_load1");
        addVec(0, 2, 99, 0, 1, 0, 1, 1,  "B_done");
        addVec(0, 2, 21, 1, 0, 0, 1, 16, "B_loop");
        // Stop while the gap is playing, then invalid selects
        addVec(0, 0, 99, 0, 0, 0, 1, 1,  "stop_gap");
        addVec(0, 0,  0, 0, 0, 0, 1, 3,  "stop_idle");
        addVec(0, -3, 0, 0, 0, 0, 1, 5,  "sel_neg3");
        addVec(0, 5,  0, 0, 0, 0, 1, 5,  "sel_5");
        // Non-looping instance, song B
        addVec(1, 2,  0, 0, 0, 0, 1, 2,  "L0_start");
        addVec(1, 2, 21, 1, 0, 0, 1, 16, "L0_note0");
        addVec(1, 2, 99, 0, 0, 0, 1, 2,  "L0_gap");
        addVec(1, 2, 99, 0, 0, 1, 1, 1,  "L0_load1");
        addVec(1, 2, 99, 0, 1, 0, 0, 1,  "L0_done");
        addVec(1, 2, 99, 0, 0, 0, 0, 55, "L0_hold");

        iReset = 1'b1;
        songsA = 5'sd1;
        songsB = 5'sd0;
        repeat (3) @(posedge iClk);
        #1;
        checkIdle("rst_held_A", dataA, strobeA, doneA, idxA);
        checkIdle("rst_held_B", dataB, strobeB, doneB, idxB);
        iReset = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.dut == 0) songsA = v.songs;
            else            songsB = v.songs;
            expQ.push_back(v);
            @(posedge iClk);
            #1;
            e = expQ.pop_front();
            checkVec(e, i);
        end

        // Asynchronous reset while song A is playing and B sits in DONE
        songsA = 5'sd1;
        found  = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge iClk);
            #1;
            if (dataA == 8'd11) found = 1'b1;
        end
        nVec++;
        if (!found) begin
            nErr++;
            $display("FAIL play_wait: got data=%0d, want 11 within 20 cycles", dataA);
        end else begin
            $display("ok   play_wait: data=11");
        end
        #2;
        iReset = 1'b1;
        #1;
        checkIdle("async_rst_A", dataA, strobeA, doneA, idxA);
        checkIdle("async_rst_B", dataB, strobeB, doneB, idxB);
        @(posedge iClk);
        #1;
        iReset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
